// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, constants and the buffered-result record for the register
// file write-side arbiter.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] X0_ADDR = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback sources, scoreboard queries and register file write port bundled
// as one interface; the arbiter is the slave, the surrounding pipeline the master.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic                  pw_valid;
  logic [REG_ADDR_W-1:0] pw_rd;
  logic [XLEN-1:0]       pw_data;
  logic                  iss_valid;
  logic [REG_ADDR_W-1:0] iss_rd;
  logic                  ll_valid;
  logic [REG_ADDR_W-1:0] ll_rd;
  logic [XLEN-1:0]       ll_data;
  logic                  ll_ready;
  logic [REG_ADDR_W-1:0] q_addr1;
  logic [REG_ADDR_W-1:0] q_addr2;
  logic                  busy1;
  logic                  busy2;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_addr;
  logic [XLEN-1:0]       rf_data;

  modport master (
    output pw_valid, pw_rd, pw_data, iss_valid, iss_rd,
           ll_valid, ll_rd, ll_data, q_addr1, q_addr2,
    input  ll_ready, busy1, busy2, rf_we, rf_addr, rf_data
  );

  modport slave (
    input  pw_valid, pw_rd, pw_data, iss_valid, iss_rd,
           ll_valid, ll_rd, ll_data, q_addr1, q_addr2,
    output ll_ready, busy1, busy2, rf_we, rf_addr, rf_data
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small circular buffer for long-latency results waiting on the write port.
// Push and pop may occur together at any occupancy; DEPTH must be a power of two.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a push at full is fine only with a pop.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter: pipeline writebacks first, then buffered long-latency
// results, then a direct long-latency bypass; tracks pending long-latency writes.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  wb
);

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  wb_entry_t             fifo_head;
  wb_entry_t             ll_entry;
  logic                  ll_acc;

  logic                  commit;
  logic                  commit_ll;
  logic                  bypass;
  logic [REG_ADDR_W-1:0] c_rd;
  logic [XLEN-1:0]       c_data;

  logic [NUM_REGS-1:0]   sb;
  logic [NUM_REGS-1:0]   sb_next;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_addr;
  logic [XLEN-1:0]       rf_data;

  assign ll_entry = '{rd: wb.ll_rd, data: wb.ll_data};
  assign ll_acc   = wb.ll_valid && !fifo_full;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (ll_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    commit    = 1'b0;
    commit_ll = 1'b0;
    bypass    = 1'b0;
    fifo_pop  = 1'b0;
    c_rd      = wb.pw_rd;
    c_data    = wb.pw_data;
    if (wb.pw_valid) begin
      commit = 1'b1;
    end else if (!fifo_empty) begin
      commit    = 1'b1;
      commit_ll = 1'b1;
      fifo_pop  = 1'b1;
      c_rd      = fifo_head.rd;
      c_data    = fifo_head.data;
    end else if (ll_acc) begin
      commit    = 1'b1;
      commit_ll = 1'b1;
      bypass    = 1'b1;
      c_rd      = wb.ll_rd;
      c_data    = wb.ll_data;
    end
  end

  assign fifo_push = ll_acc && !bypass;

  // Issue is applied after the clear so a same-cycle reissue keeps the bit set.
  always_comb begin
    sb_next = sb;
    if (commit_ll) sb_next[c_rd] = 1'b0;
    if (wb.iss_valid && (wb.iss_rd != X0_ADDR)) sb_next[wb.iss_rd] = 1'b1;
    sb_next[X0_ADDR] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb      <= '0;
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else begin
      sb    <= sb_next;
      rf_we <= commit && (c_rd != X0_ADDR);
      if (commit) begin
        rf_addr <= c_rd;
        rf_data <= c_data;
      end
    end
  end

  assign wb.ll_ready = !fifo_full;
  assign wb.busy1    = (wb.q_addr1 != X0_ADDR) && sb[wb.q_addr1];
  assign wb.busy2    = (wb.q_addr2 != X0_ADDR) && sb[wb.q_addr2];
  assign wb.rf_we    = rf_we;
  assign wb.rf_addr  = rf_addr;
  assign wb.rf_data  = rf_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised plus directed stimulus for the writeback arbiter, checked by a
// queue-based reference model and an independent commit monitor.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int DEPTH = 2;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  regfile_wb_arbiter_if ifc ();

  regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  wb_entry_t  m_buf[$];
  wb_entry_t  ll_pend[$];
  exp_t       exp_q[$];
  bit [31:0]  m_busy;
  exp_t       mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (ifc.rf_we !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got we=%b addr %0d data %0h, expected no write (cycle %0d)",
                 ifc.rf_we, ifc.rf_addr, ifc.rf_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("commit_addr", 32'(ifc.rf_addr), 32'(mon_e.rd));
        chk("commit_data", ifc.rf_data, mon_e.data);
        chk("commit_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // One clock: entered 1 time unit after posedge, leaves 1 unit after the next.
  task automatic step(input bit pv, input logic [4:0] prd, input logic [31:0] pd,
                      input bit iv, input logic [4:0] ird,
                      input logic [4:0] q1, input logic [4:0] q2);
    bit        ready, acc, cm, cm_ll;
    wb_entry_t c;
    ifc.pw_valid  = pv;
    ifc.pw_rd     = prd;
    ifc.pw_data   = pd;
    ifc.iss_valid = iv;
    ifc.iss_rd    = ird;
    ifc.ll_valid  = (ll_pend.size() > 0);
    ifc.ll_rd     = (ll_pend.size() > 0) ? ll_pend[0].rd   : 5'd0;
    ifc.ll_data   = (ll_pend.size() > 0) ? ll_pend[0].data : 32'd0;
    ifc.q_addr1   = q1;
    ifc.q_addr2   = q2;
    n_vec++;
    @(negedge clk);
    ready = (m_buf.size() < DEPTH);
    chk("ll_ready", 32'(ifc.ll_ready), 32'(ready));
    chk("busy1", 32'(ifc.busy1), 32'((q1 != 0) && m_busy[q1]));
    chk("busy2", 32'(ifc.busy2), 32'((q2 != 0) && m_busy[q2]));
    acc = (ll_pend.size() > 0) && ready;
    if (acc) m_buf.push_back(ll_pend.pop_front());
    cm = 1'b0;
    cm_ll = 1'b0;
    if (pv) begin
      cm = 1'b1;
      c  = '{rd: prd, data: pd};
    end else if (m_buf.size() > 0) begin
      cm    = 1'b1;
      cm_ll = 1'b1;
      c     = m_buf.pop_front();
    end
    if (cm && c.rd != 0) exp_q.push_back('{rd: c.rd, data: c.data, cyc: cyc + 1});
    if (cm_ll) m_busy[c.rd] = 1'b0;
    if (iv && ird != 0) m_busy[ird] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [4:0] q1);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, q1, 5'($urandom));
  endtask

  task automatic quiet_inputs();
    ifc.pw_valid = 0; ifc.pw_rd = 0; ifc.pw_data = 0;
    ifc.iss_valid = 0; ifc.iss_rd = 0;
    ifc.ll_valid = 0; ifc.ll_rd = 0; ifc.ll_data = 0;
    ifc.q_addr1 = 0; ifc.q_addr2 = 0;
  endtask

  initial begin
    quiet_inputs();
    m_busy = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rf_we", 32'(ifc.rf_we), 0);
    chk("reset_rf_addr", 32'(ifc.rf_addr), 0);
    chk("reset_rf_data", ifc.rf_data, 0);
    chk("reset_ll_ready", 32'(ifc.ll_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Pipeline writeback, single-cycle latency
    step(1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
    idle(2, 5);

    // Issue rd 7, then bypassed long-latency result for rd 7
    step(0, 0, 0, 1, 7, 7, 0);
    ll_pend.push_back('{rd: 7, data: 32'h11});
    step(0, 0, 0, 0, 0, 7, 7);
    idle(2, 7);

    // Pipeline holds the port while three results arrive
    for (int r = 1; r <= 3; r++) begin
      step(0, 0, 0, 1, 5'(r), 5'(r), 0);
      ll_pend.push_back('{rd: 5'(r), data: 32'h100 + r});
    end
    for (int i = 0; i < 4; i++) step(1, 5'(10 + i), 32'hA0 + i, 0, 0, 1, 3);
    idle(5, 2);

    // Same-cycle reissue and commit of rd 9
    step(0, 0, 0, 1, 9, 9, 0);
    ll_pend.push_back('{rd: 9, data: 32'h99});
    step(0, 0, 0, 1, 9, 9, 0);
    idle(2, 9);

    // rd 0 writes from both sources are dropped
    step(1, 0, 32'h1234, 1, 0, 0, 0);
    ll_pend.push_back('{rd: 0, data: 32'h5678});
    idle(3, 0);

    // Fill the buffer, set busy bits, then reset mid-operation
    step(0, 0, 0, 1, 12, 12, 0);
    step(0, 0, 0, 1, 13, 13, 12);
    for (int r = 20; r <= 22; r++) ll_pend.push_back('{rd: 5'(r), data: 32'hC0 + r});
    for (int i = 0; i < 3; i++) step(1, 5'(24 + i), 32'hB0 + i, 0, 0, 12, 13);
    ifc.q_addr1 = 12;
    ifc.q_addr2 = 13;
    rst = 1'b1;
    #1;
    chk("midrst_rf_we", 32'(ifc.rf_we), 0);
    chk("midrst_ll_ready", 32'(ifc.ll_ready), 1);
    chk("midrst_busy1", 32'(ifc.busy1), 0);
    chk("midrst_busy2", 32'(ifc.busy2), 0);
    chk("midrst_rf_addr", 32'(ifc.rf_addr), 0);
    m_buf.delete();
    ll_pend.delete();
    exp_q.delete();
    m_busy = '0;
    quiet_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(2, 12);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (ll_pend.size() < 2 && $urandom_range(0, 99) < 45)
        ll_pend.push_back('{rd: 5'($urandom), data: $urandom});
      step($urandom_range(0, 99) < 40, 5'($urandom), $urandom,
           $urandom_range(0, 99) < 30, 5'($urandom),
           5'($urandom), 5'($urandom));
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 5'($urandom), 5'($urandom));
    chk("drain_expected", exp_q.size(), 0);
    chk("drain_pending", ll_pend.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-side front end for the general register file: merges single-cycle pipeline writebacks with results returned by long-latency units (multiplier/divider, memory loads) onto the register file's single write port. Holds long-latency results in a 2-entry FIFO when the port is busy, and keeps a 32-bit scoreboard of registers with outstanding long-latency writes so decode can stall on RAW/WAW hazards. Sits between the WB stage / long-latency units and the register file's `write_en`/`wb_addr`/`wb_data` inputs.

## Interface
- `FIFO_DEPTH`, 2, long-latency result buffer entries (power of two, ≥2)
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  reset, asynchronous, active-high
- `pw_valid`  in  1  pipeline writeback request this cycle
- `pw_rd`  in  5  pipeline destination register
- `pw_data`  in  32  pipeline writeback data
- `iss_valid`  in  1  a long-latency op with destination `iss_rd` issues this cycle
- `iss_rd`  in  5  destination of issuing long-latency op
- `ll_valid`  in  1  long-latency result offered
- `ll_rd`  in  5  long-latency result destination
- `ll_data`  in  32  long-latency result data
- `ll_ready`  out  1  result accepted when `ll_valid && ll_ready`
- `q_addr1`, `q_addr2`  in  5  decode-stage source register queries
- `busy1`, `busy2`  out  1  scoreboard bit for `q_addr1`/`q_addr2` (combinational; 0 for x0)
- `rf_we`  out  1  register file write enable (registered)
- `rf_addr`  out  5  register file write address (registered)
- `rf_data`  out  32  register file write data (registered)

## Operation
- Reset: FIFO empty, scoreboard all 0, `rf_we`=0, `rf_addr`=0, `rf_data`=0, `ll_ready`=1.
- Each cycle exactly one commit source is chosen, priority: (1) `pw_valid`, (2) FIFO head, (3) direct bypass of `ll_valid` when FIFO empty.
- Commit: next posedge loads `rf_we`=1, `rf_addr`, `rf_data`; no commit → `rf_we`=0, addr/data hold.
- Writes with rd=0 are committed as `rf_we`=0 (dropped), still consume the slot/entry.
- `ll_ready` = FIFO not full (from registered count). Accepted result enters FIFO unless it is taken by bypass in the same cycle.
- FIFO full and `pw_valid` every cycle: FIFO stalls, `ll_ready`=0; no data loss, order preserved.
- Simultaneous FIFO pop and push allowed in the same cycle at any occupancy including full-minus-one.
- Scoreboard: `iss_valid && iss_rd!=0` sets bit `iss_rd`; commit of a long-latency result (FIFO or bypass) clears bit `rd`. Same-register set and clear in one cycle → bit ends 1.
- Pipeline writebacks never touch the scoreboard; a pipeline write to a busy register is committed normally.
- `busyN` reflects registered scoreboard only (no same-cycle issue/commit bypass).

## Timing
- Pipeline writeback: `pw_valid` at cycle N → `rf_we`=1 during cycle N+1 → register file stores at negedge of N+1; visible to reads from that negedge.
- Bypass long-latency result: same 1-cycle latency when FIFO empty and no `pw_valid`.
- Buffered result: commits earliest the cycle after the last consecutive `pw_valid`.
- Scoreboard bit set visible on `busyN` the cycle after issue; cleared the cycle after commit decision (same edge `rf_we` rises).
- `rst` asserted mid-operation: FIFO contents and scoreboard discarded immediately; `rf_we` drops asynchronously.

## Structure
- Shared package: `REG_ADDR_W`=5, `XLEN`=32, `NUM_REGS`=32, x0 address constant.
- One sub-module: `wb_fifo` (parameterised depth, push/pop/full/empty, simultaneous push+pop); arbiter, scoreboard, and output registers stay in the top.

## Test plan
- Reset then `pw_valid`, rd=5, data=0xDEADBEEF → next cycle `rf_we`=1, `rf_addr`=5, `rf_data`=0xDEADBEEF; `busy` all 0.
- Issue rd=7, then `ll_valid` rd=7 data=0x11 with FIFO empty, no pw → `busy1`(q=7)=1 until commit; commit next cycle, busy falls same edge.
- `pw_valid` held 4 cycles while 3 ll results (rd 1,2,3) offered → first two accepted, `ll_ready`=0 for the third until a pop; commits order pw×4, then 1,2,3.
- Same cycle `iss_valid` rd=9 and ll commit rd=9 → scoreboard bit 9 remains 1.
- Writes to rd=0 from both sources → `rf_we` never asserts; `busy` for q=0 always 0.
- `rst` pulsed with FIFO full and scoreboard bits set → all cleared, `ll_ready`=1, `rf_we`=0 immediately.
